// File: rtl/trans_est_param.sv
// Transmission estimation, parametrised.
// Per 3x3 window of NCH-channel pixels:
//   t = max(T0, 1 - omega * min_window(min_ch(I/A)))
// The pipeline has four stages (normalise, channel min, window min, transmission).
// It accepts one window per cycle and has no backpressure.

// One window pixel: normalise each channel by inverse A (S1), then take the
// minimum over the channels (S2).
module trans_est_pix #(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int INV_W  = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NCH-1:0][DATA_W-1:0]    pix,
  input  logic [NCH-1:0][INV_W-1:0]     inv,
  output logic [DATA_W-1:0]             ch_min
);
  localparam int PW = DATA_W + INV_W;
  localparam int SW = PW - 8;
  localparam logic [SW-1:0] SAT = SW'((1 << DATA_W) - 1);

  logic [NCH-1:0][DATA_W-1:0] norm_nx, norm_q;
  logic [DATA_W-1:0]          min_nx;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SW-1:0] sh;
    // Q8 scale: inv = 2^16/A, so (p*inv)>>8 is p/A in DATA_W-bit full scale.
    assign sh         = SW'((PW'(pix[c]) * PW'(inv[c])) >> 8);
    assign norm_nx[c] = (sh > SAT) ? {DATA_W{1'b1}} : sh[DATA_W-1:0];
  end

  // S1 register: saturated normalised channels
  always_ff @(posedge clk) begin
    if (rst) norm_q <= '0;
    else     norm_q <= norm_nx;
  end

  // minimum over the channels of this pixel
  always_comb begin
    min_nx = norm_q[0];
    for (int c = 1; c < NCH; c++)
      if (norm_q[c] < min_nx) min_nx = norm_q[c];
  end

  // S2 register: per-pixel channel minimum
  always_ff @(posedge clk) begin
    if (rst) ch_min <= '0;
    else     ch_min <= min_nx;
  end
endmodule

module trans_est_param #(
  parameter int DATA_W      = 8,
  parameter int NCH         = 3,
  parameter int INV_W       = 9,
  parameter int INV_DEFAULT = 315,
  parameter int OMEGA       = 243,
  parameter int T0          = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [9*NCH*DATA_W-1:0] in_win,
  input  logic                    frame_start,
  input  logic                    atm_sel,
  input  logic                    atm_valid,
  input  logic [NCH*INV_W-1:0]    atm_inv,
  output logic [DATA_W-1:0]       transmission,
  output logic [DATA_W-1:0]       dark_out,
  output logic                    trans_valid,
  output logic                    atm_captured,
  output logic                    atm_active
);
  localparam int NPIX   = 9;
  localparam int STAGES = 4;
  localparam logic [INV_W-1:0]  INV_DEF = INV_W'(INV_DEFAULT);
  localparam logic [DATA_W-1:0] MAXV    = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] T0_L    = DATA_W'(T0);

  logic [NPIX-1:0][NCH-1:0][DATA_W-1:0] win;
  logic [NCH-1:0][INV_W-1:0]            ale_inv, inv_def, shadow, active, inv_next;
  logic [NPIX-1:0][DATA_W-1:0]          pix_min;
  logic [DATA_W-1:0]                    win_min, dark_s3, d_sc, t_raw, t_cl;
  logic [STAGES:1]                      vld_pipe;
  logic                                 frame_sw, use_ale;

  assign win      = in_win;
  assign ale_inv  = atm_inv;
  assign inv_def  = {NCH{INV_DEF}};
  assign frame_sw = in_valid & frame_start;
  // A same-cycle ALE strobe counts as captured, so it can be used at once.
  assign use_ale  = atm_sel & (atm_captured | atm_valid);

  // Inverse A seen by S1 this cycle: the frame_start window already uses the new value.
  always_comb begin
    inv_next = active;
    if (frame_sw)
      inv_next = use_ale ? (atm_valid ? ale_inv : shadow) : inv_def;
  end

  // ALE shadow capture; the active set only changes at an accepted frame_start
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= inv_def;
      active       <= inv_def;
      atm_captured <= 1'b0;
      atm_active   <= 1'b0;
    end else begin
      if (atm_valid) begin
        shadow       <= ale_inv;
        atm_captured <= 1'b1;
      end
      if (frame_sw) begin
        active     <= inv_next;
        atm_active <= use_ale;
      end
    end
  end

  // valid shift register, one bit per stage; bubbles flow through as zeros
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end
  assign trans_valid = vld_pipe[STAGES];

  for (genvar k = 0; k < NPIX; k++) begin : g_pix
    trans_est_pix #(.DATA_W(DATA_W), .NCH(NCH), .INV_W(INV_W)) u_pix (
      .clk    (clk),
      .rst    (rst),
      .pix    (win[k]),
      .inv    (inv_next),
      .ch_min (pix_min[k])
    );
  end

  // minimum over the nine pixel minima
  always_comb begin
    win_min = pix_min[0];
    for (int k = 1; k < NPIX; k++)
      if (pix_min[k] < win_min) win_min = pix_min[k];
  end

  // S3 register: dark channel
  always_ff @(posedge clk) begin
    if (rst) dark_s3 <= '0;
    else     dark_s3 <= win_min;
  end

  // OMEGA <= 255 keeps d within DATA_W bits, so the subtraction cannot wrap
  assign d_sc  = DATA_W'(((DATA_W+8)'(OMEGA) * (DATA_W+8)'(dark_s3)) >> 8);
  assign t_raw = MAXV - d_sc;
  assign t_cl  = (t_raw < T0_L) ? T0_L : t_raw;

  // S4 register: transmission, with dark_out delayed to line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      transmission <= '0;
      dark_out     <= '0;
    end else begin
      transmission <= t_cl;
      dark_out     <= dark_s3;
    end
  end
endmodule

// File: tb/tb_trans_est_param.sv
// Scoreboard bench for trans_est_param. The stimulus pushes hand-computed
// expectations, and a negedge monitor pops them when trans_valid is high.
module tb_trans_est_param;
  localparam int DATA_W = 8;
  localparam int NCH    = 3;
  localparam int INV_W  = 9;
  localparam int WW     = 9*NCH*DATA_W;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, frame_start, atm_sel, atm_valid;
  logic [WW-1:0]        in_win;
  logic [NCH*INV_W-1:0] atm_inv;
  logic [DATA_W-1:0]    transmission, dark_out;
  logic                 trans_valid, atm_captured, atm_active;

  trans_est_param dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_win       (in_win),
    .frame_start  (frame_start),
    .atm_sel      (atm_sel),
    .atm_valid    (atm_valid),
    .atm_inv      (atm_inv),
    .transmission (transmission),
    .dark_out     (dark_out),
    .trans_valid  (trans_valid),
    .atm_captured (atm_captured),
    .atm_active   (atm_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] t;
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: every valid output must match the oldest pending expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (trans_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got t=%0d d=%0d expected no output", transmission, dark_out);
      end else begin
        e = sb.pop_front();
        chk("transmission", 32'(transmission), 32'(e.t));
        chk("dark_out", 32'(dark_out), 32'(e.d));
        chk("latency", 32'(cyc - e.c), 32'd4);
      end
    end
  end

  function automatic logic [WW-1:0] mkwin(input logic [7:0] r, g, b, g4);
    logic [8:0][2:0][7:0] w;
    for (int k = 0; k < 9; k++) begin
      w[k][0] = r; w[k][1] = g; w[k][2] = b;
    end
    w[4][1] = g4;
    return w;
  endfunction

  function automatic logic [NCH*INV_W-1:0] inv3(input logic [8:0] v);
    return {v, v, v};
  endfunction

  // one cycle of stimulus, driven 2 time units after the rising edge
  task automatic step(input logic v, fs, sel, av, input logic [NCH*INV_W-1:0] ai,
                      input logic [WW-1:0] w, input logic [7:0] et, ed);
    @(posedge clk); #2;
    in_valid = v; frame_start = fs; atm_sel = sel; atm_valid = av;
    atm_inv = ai; in_win = w;
    if (v) sb.push_back('{et, ed, cyc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 8'd0, 8'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got no finish expected finish within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [WW-1:0] w1, w3, w4;
    int n;
    w1 = mkwin(8'd100, 8'd150, 8'd200, 8'd150);
    w3 = mkwin(8'd200, 8'd200, 8'd200, 8'd10);
    w4 = mkwin(8'd255, 8'd255, 8'd255, 8'd255);
    rst = 1'b1; in_valid = 0; frame_start = 0; atm_sel = 0; atm_valid = 0;
    atm_inv = '0; in_win = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_trans_valid", 32'(trans_valid), 0);
    chk("rst_transmission", 32'(transmission), 0);
    chk("rst_dark_out", 32'(dark_out), 0);
    chk("rst_atm_captured", 32'(atm_captured), 0);
    chk("rst_atm_active", 32'(atm_active), 0);
    rst = 1'b0;

    // default inverse A (315): dark 123, t 139
    step(1, 1, 0, 0, '0, w1, 8'd139, 8'd123);
    step(1, 0, 0, 0, '0, w1, 8'd139, 8'd123);
    chk("t1_atm_active", 32'(atm_active), 0);
    // mid-frame ALE strobe and atm_sel leave the active values alone
    step(1, 0, 0, 1, inv3(9'd256), w1, 8'd139, 8'd123);
    step(1, 0, 1, 0, '0, w1, 8'd139, 8'd123);
    chk("t2_captured_mid", 32'(atm_captured), 1);
    chk("t2_active_mid", 32'(atm_active), 0);
    // next frame with atm_sel=1 switches to 256: dark 100, t 161
    step(1, 1, 1, 0, '0, w1, 8'd161, 8'd100);
    step(1, 0, 0, 0, '0, w1, 8'd161, 8'd100);
    chk("t2_atm_active", 32'(atm_active), 1);
    chk("t2_atm_captured", 32'(atm_captured), 1);
    // frame_start without in_valid is ignored
    step(0, 1, 0, 0, '0, '0, 8'd0, 8'd0);
    step(1, 0, 0, 0, '0, w1, 8'd161, 8'd100);
    chk("fs_no_valid_active", 32'(atm_active), 1);
    // channel and window minima: only pixel 4 G=10
    step(1, 0, 0, 0, '0, w3, 8'd246, 8'd10);
    // saturation 313 -> 255 and the T0 clamp
    step(1, 1, 0, 0, '0, w4, 8'd26, 8'd255);
    step(1, 0, 0, 0, '0, w4, 8'd26, 8'd255);
    chk("t4_atm_active", 32'(atm_active), 0);
    idle(6);

    // atm_sel before any capture falls back to the default
    @(posedge clk); #2; rst = 1'b1; in_valid = 0;
    @(posedge clk); #2; rst = 1'b0;
    step(1, 1, 1, 0, '0, w1, 8'd139, 8'd123);
    step(1, 0, 0, 0, '0, w1, 8'd139, 8'd123);
    chk("t5_active_nocap", 32'(atm_active), 0);
    chk("t5_captured_nocap", 32'(atm_captured), 0);
    // same-cycle atm_valid + frame_start uses the new value immediately
    step(1, 1, 1, 1, inv3(9'd256), w1, 8'd161, 8'd100);
    step(1, 0, 0, 0, '0, w1, 8'd161, 8'd100);
    chk("t5_active_same", 32'(atm_active), 1);
    chk("t5_captured_same", 32'(atm_captured), 1);
    idle(6);

    // reset with windows in flight: nothing comes out for them
    step(1, 0, 0, 0, '0, w1, 8'd0, 8'd0);
    step(0, 0, 0, 0, '0, '0, 8'd0, 8'd0);
    step(1, 0, 0, 0, '0, w1, 8'd0, 8'd0);
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b1; in_win = w1;
    sb.delete();
    @(posedge clk); #2;
    chk("t6_trans_valid", 32'(trans_valid), 0);
    chk("t6_transmission", 32'(transmission), 0);
    chk("t6_dark_out", 32'(dark_out), 0);
    chk("t6_atm_active", 32'(atm_active), 0);
    chk("t6_atm_captured", 32'(atm_captured), 0);
    rst = 1'b0; in_valid = 1'b0;
    idle(5);
    // active inverse values are back to 315 without any frame_start
    step(1, 0, 0, 0, '0, w1, 8'd139, 8'd123);
    step(1, 1, 1, 0, '0, w1, 8'd139, 8'd123);
    idle(2);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trans_est_param.md
Name: trans_est_param

Overview:
- Parametrised successor to the fixed transmission-estimation top.
- Consumes one 3x3 window of NCH-channel pixels per cycle from the window generator and emits one transmission value per cycle:
  t = max(T0, 1 − ω·min_window(min_ch(I/A)))
- Inverse atmospheric light is selectable per frame between a parameter default and the ALE block's output. ALE updates are staged in shadow registers and applied only at frame boundaries.

Parameters:
- DATA_W, 8, pixel channel width and transmission width.
- NCH, 3, channels per pixel.
- INV_W, 9, inverse-atmospheric-light width; unsigned, value = round(2^16/A).
- INV_DEFAULT, 315, inverse A used when ALE is not selected or not yet captured.
- OMEGA, 243, haze-retention factor in Q0.8 (0.95).
- T0, 26, lower clamp on transmission (about 0.1 in Q0.8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  window valid.
- in_win  in  9*NCH*DATA_W  flattened window; pixel k (0..8) at bits [(k+1)*NCH*DATA_W-1 : k*NCH*DATA_W], channel c at offset c*DATA_W.
- frame_start  in  1  asserted with the first valid window of a frame.
- atm_sel  in  1  0 = INV_DEFAULT, 1 = ALE values; sampled at frame_start.
- atm_valid  in  1  ALE strobe.
- atm_inv  in  NCH*INV_W  ALE inverse-A per channel.
- transmission  out  DATA_W  transmission value.
- dark_out  out  DATA_W  normalised dark-channel value (debug).
- trans_valid  out  1  output valid.
- atm_captured  out  1  at least one ALE value captured since reset.
- atm_active  out  1  current frame is using ALE values.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - transmission, dark_out, trans_valid, atm_captured, atm_active = 0.
  - Shadow and active inverse registers = INV_DEFAULT for every channel.
  - Pipeline valid bits cleared.
- Reset mid-frame discards all in-flight windows. No output is produced for them.
- Throughput is one window per cycle. There is no backpressure. in_valid=0 inserts a bubble that propagates as trans_valid=0.
- Latency is fixed at 4 cycles from in_valid to trans_valid:
  - S1: per pixel and channel, n = (p·inv_c) >> 8, saturated to 2^DATA_W−1. The product is DATA_W+INV_W bits.
  - S2: per pixel, minimum over channels.
  - S3: minimum over the 9 pixels. The result is registered as dark_out.
  - S4: d = (OMEGA·dark) >> 8; t = (2^DATA_W−1) − d; if t < T0 then t = T0. Registered to transmission; trans_valid asserts.
- dark_out is aligned with transmission: delayed one stage so both change on the same edge.
- Shadow capture: on atm_valid, the shadow registers load atm_inv and atm_captured is set. atm_captured stays 1 until reset.
- Frame switch, on frame_start with in_valid:
  - If atm_sel=1 and atm_captured is 1 (or atm_valid is asserted in the same cycle): active <= shadow, or <= atm_inv if atm_valid is asserted that cycle; atm_active=1.
  - Otherwise: active <= INV_DEFAULT; atm_active=0.
  - The window accepted in the frame_start cycle already uses the new active value. S1 muxes the next-active value.
- atm_valid in mid-frame never alters the active registers. Only the latest shadow value is applied at the next frame_start.
- frame_start without in_valid is ignored.
- atm_sel is ignored outside frame_start cycles.
- No overflow: OMEGA ≤ 255 guarantees d ≤ 2^DATA_W−1.

Test Plan:
1. Reset, atm_sel=0, uniform window of (100,150,200), frame_start on the first window:
   - Expected (INV_DEFAULT=315): norm R = 100·315>>8 = 123; dark = 123; d = 243·123>>8 = 116; transmission = 139.
   - trans_valid exactly 4 cycles after in_valid.
2. atm_valid with inv=256 for all channels mid-frame, same window:
   - Output stays 139 until the next frame_start with atm_sel=1.
   - After that frame_start: dark = 100, transmission = 161, atm_active = 1, atm_captured = 1.
3. inv=256, all pixels (200,200,200) except pixel 4 with G=10:
   - dark_out = 10, transmission = 246.
   - Verifies the channel and window minima.
4. inv=315, all pixels 255:
   - Saturation: 313 → 255; dark = 255; d = 242; t = 13, clamped to T0 = 26.
5. atm_sel=1 at frame_start before any atm_valid:
   - Uses INV_DEFAULT; atm_active = 0.
   - Then atm_valid and frame_start in the same cycle with inv=256: that window already uses 256.
6. Alternating in_valid, with rst asserted while 3 windows are in flight:
   - No trans_valid for those windows; all outputs 0 on the next cycle.
   - Active inverse values return to 315.
